// File: rtl/cb_cfg_pkg.sv
// Select-code constants and parity helper shared by the X-channel connection block.
package cb_cfg_pkg;

    localparam int SEL_ZERO      = 0;
    localparam int SEL_LEFT_BASE = 1;
    localparam int PAR_MAX_W     = 256;

    // Right-side codes start right after the last left-side code.
    function automatic int sel_right_base(input int chan_w);
        return chan_w + SEL_LEFT_BASE;
    endfunction

    function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/cbx_cfg_shadow_param_if.sv
// Configuration-chain bundle between a tile's config driver and the connection block.
interface cbx_cfg_shadow_param_if;

    // No valid/ready here: ccff_en qualifies ccff_head for exactly one bit per cycle,
    // ccff_commit is a single-cycle pulse, and the block can never stall the chain.
    logic ccff_head;
    logic ccff_en;
    logic ccff_commit;
    logic ccff_tail;
    logic cfg_valid;
    logic cfg_err;

    modport master (
        output ccff_head, ccff_en, ccff_commit,
        input  ccff_tail, cfg_valid, cfg_err
    );

    modport slave (
        input  ccff_head, ccff_en, ccff_commit,
        output ccff_tail, cfg_valid, cfg_err
    );

endinterface

// File: rtl/cb_pin_mux.sv
// One outpad pin: decodes a select code over left and right channel tracks.
module cb_pin_mux
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W = 20,
    parameter int SEL_W  = 6
) (
    input  logic [SEL_W-1:0]  i_sel,
    input  logic              i_en,
    input  logic [CHAN_W-1:0] i_left,
    input  logic [CHAN_W-1:0] i_right,
    output logic              o_pin
);

    // Codes past the last right-side track fall through to the default 0.
    always_comb begin
        o_pin = 1'b0;
        if (i_en && int'(i_sel) != SEL_ZERO) begin
            for (int i = 0; i < CHAN_W; i++) begin
                if (int'(i_sel) == SEL_LEFT_BASE + i) o_pin = i_left[i];
                if (int'(i_sel) == sel_right_base(CHAN_W) + i) o_pin = i_right[i];
            end
        end
    end

endmodule

// File: rtl/cbx_cfg_shadow_param.sv
// X-channel connection block for the bottom I/O row: serial config shift register,
// parity-checked commit into a shadow register, and per-pin track muxes.
module cbx_cfg_shadow_param
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W    = 20,
    parameter int NUM_PINS  = 9,
    parameter int SEL_W     = $clog2(2*CHAN_W+1),
    parameter int FRAME_LEN = NUM_PINS*SEL_W+1
) (
    input  logic                             prog_clk,
    input  logic                             pReset,
    cbx_cfg_shadow_param_if.slave            cfg,
    input  logic [CHAN_W-1:0]                chanx_left_in,
    input  logic [CHAN_W-1:0]                chanx_right_in,
    output logic [CHAN_W-1:0]                chanx_left_out,
    output logic [CHAN_W-1:0]                chanx_right_out,
    output logic [NUM_PINS-1:0]              pin_outpad,
    output logic [$clog2(FRAME_LEN+1)-1:0]   dbg_cnt
);

    localparam int PAY_W = NUM_PINS*SEL_W;
    localparam int CNT_W = $clog2(FRAME_LEN+1);

    logic [FRAME_LEN-1:0] r_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic [PAY_W-1:0]     r_shadow;
    logic                 r_valid;
    logic                 r_err;
    logic                 w_good;

    assign w_good = (r_cnt == CNT_W'(FRAME_LEN)) && !odd_parity(PAR_MAX_W'(r_sr));

    // Commit looks at the pre-edge shift register, so a same-cycle shift bit starts the next frame.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (cfg.ccff_en) r_sr <= {r_sr[FRAME_LEN-2:0], cfg.ccff_head};
            if (cfg.ccff_commit) begin
                r_cnt <= cfg.ccff_en ? CNT_W'(1) : '0;
                if (w_good) begin
                    r_shadow <= r_sr[PAY_W-1:0];
                    r_valid  <= 1'b1;
                    r_err    <= 1'b0;
                end else begin
                    r_err    <= 1'b1;
                end
            end else if (cfg.ccff_en && r_cnt != CNT_W'(FRAME_LEN)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cfg.ccff_tail  = r_sr[FRAME_LEN-1];
    assign cfg.cfg_valid  = r_valid;
    assign cfg.cfg_err    = r_err;
    assign dbg_cnt        = r_cnt;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    for (genvar k = 0; k < NUM_PINS; k++) begin : g_pin
        cb_pin_mux #(
            .CHAN_W (CHAN_W),
            .SEL_W  (SEL_W)
        ) u_mux (
            .i_sel   (r_shadow[k*SEL_W +: SEL_W]),
            .i_en    (r_valid),
            .i_left  (chanx_left_in),
            .i_right (chanx_right_in),
            .o_pin   (pin_outpad[k])
        );
    end

endmodule

// File: tb/tb_cbx_cfg_shadow_param.sv
// Directed bench for cbx_cfg_shadow_param at default parameters (20 tracks, 9 pins, 55-bit frame).
module tb_cbx_cfg_shadow_param;

    localparam int CHAN_W    = 20;
    localparam int NUM_PINS  = 9;
    localparam int FRAME_LEN = 55;

    // Hand-built frames: bit 54 is parity, pin k select at [6k +: 6].
    // A: pin0=3, pin8=25 (5 ones -> parity 1)
    localparam logic [FRAME_LEN-1:0] FRAME_A     = 55'h59000000000003;
    localparam logic [FRAME_LEN-1:0] FRAME_A_BAD = 55'h19000000000003;
    // B: pin1=40, pin2=20 (4 ones -> parity 0)
    localparam logic [FRAME_LEN-1:0] FRAME_B     = 55'h00000000014A00;
    // C: pin3=1, pin4=21 (4 ones -> parity 0)
    localparam logic [FRAME_LEN-1:0] FRAME_C     = 55'h00000015040000;
    // D: pin0=41, pin1=40 (5 ones -> parity 1)
    localparam logic [FRAME_LEN-1:0] FRAME_D     = 55'h40000000000A29;

    logic                prog_clk = 1'b0;
    logic                pReset;
    logic [CHAN_W-1:0]   left_in, right_in, left_out, right_out;
    logic [NUM_PINS-1:0] pins;
    logic [5:0]          dbg_cnt;

    cbx_cfg_shadow_param_if u_cfg ();

    cbx_cfg_shadow_param dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .cfg             (u_cfg),
        .chanx_left_in   (left_in),
        .chanx_right_in  (right_in),
        .chanx_left_out  (left_out),
        .chanx_right_out (right_out),
        .pin_outpad      (pins),
        .dbg_cnt         (dbg_cnt)
    );

    // clock / watchdog
    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       tail_chk = 1'b0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b, input logic with_commit);
        u_cfg.ccff_head   = b;
        u_cfg.ccff_en     = 1'b1;
        u_cfg.ccff_commit = with_commit;
        tick();
        u_cfg.ccff_en     = 1'b0;
        u_cfg.ccff_commit = 1'b0;
        if (tail_chk) begin
            exp_q.push_back(b);
            if (exp_q.size() > FRAME_LEN) void'(exp_q.pop_front());
            if (exp_q.size() == FRAME_LEN) check("tail", 64'(u_cfg.ccff_tail), 64'(exp_q[0]));
        end
    endtask

    task automatic shift_frame(input logic [FRAME_LEN-1:0] f, input int n);
        for (int i = FRAME_LEN-1; i >= FRAME_LEN-n; i--) shift_bit(f[i], 1'b0);
    endtask

    task automatic commit();
        u_cfg.ccff_commit = 1'b1;
        tick();
        u_cfg.ccff_commit = 1'b0;
    endtask

    initial begin
        pReset            = 1'b1;
        u_cfg.ccff_head   = 1'b0;
        u_cfg.ccff_en     = 1'b0;
        u_cfg.ccff_commit = 1'b0;
        left_in           = '0;
        right_in          = '0;
        tick();
        tick();

        // 1: reset holds everything at 0 even with all inputs high
        u_cfg.ccff_head   = 1'b1;
        u_cfg.ccff_en     = 1'b1;
        u_cfg.ccff_commit = 1'b1;
        left_in           = '1;
        right_in          = '1;
        tick();
        check("rst_pins",  64'(pins), 64'(0));
        check("rst_tail",  64'(u_cfg.ccff_tail), 64'(0));
        check("rst_valid", 64'(u_cfg.cfg_valid), 64'(0));
        check("rst_err",   64'(u_cfg.cfg_err), 64'(0));
        check("rst_cnt",   64'(dbg_cnt), 64'(0));
        check("rst_lout",  64'(left_out), 64'(20'hFFFFF));
        pReset            = 1'b0;
        u_cfg.ccff_head   = 1'b0;
        u_cfg.ccff_en     = 1'b0;
        u_cfg.ccff_commit = 1'b0;
        left_in           = 20'hA5A5A;
        right_in          = 20'h0F0F3;
        #1;
        check("pass_rout", 64'(right_out), 64'(20'hA5A5A));
        check("pass_lout", 64'(left_out), 64'(20'h0F0F3));

        // 2: good frame A
        shift_frame(FRAME_A, FRAME_LEN);
        check("s2_cnt_full", 64'(dbg_cnt), 64'(55));
        check("s2_pre_valid", 64'(u_cfg.cfg_valid), 64'(0));
        commit();
        left_in  = 20'h00004;
        right_in = 20'h00010;
        #1;
        check("s2_valid", 64'(u_cfg.cfg_valid), 64'(1));
        check("s2_err",   64'(u_cfg.cfg_err), 64'(0));
        check("s2_pins",  64'(pins), 64'(9'h101));
        check("s2_cnt",   64'(dbg_cnt), 64'(0));
        left_in  = 20'hFFFFB;
        right_in = 20'hFFFEF;
        #1;
        check("s2_pins_inv", 64'(pins), 64'(9'h000));
        left_in  = 20'h00004;
        right_in = 20'h00010;

        // 3: parity flipped -> rejected, shadow kept
        shift_frame(FRAME_A_BAD, FRAME_LEN);
        commit();
        check("s3_err",   64'(u_cfg.cfg_err), 64'(1));
        check("s3_valid", 64'(u_cfg.cfg_valid), 64'(1));
        check("s3_pins",  64'(pins), 64'(9'h101));

        // 4: recover, then short frame rejected, then good frame B
        shift_frame(FRAME_A, FRAME_LEN);
        commit();
        check("s4_recover_err", 64'(u_cfg.cfg_err), 64'(0));
        shift_frame(FRAME_B, 54);
        check("s4_cnt54", 64'(dbg_cnt), 64'(54));
        commit();
        check("s4_short_err", 64'(u_cfg.cfg_err), 64'(1));
        check("s4_short_cnt", 64'(dbg_cnt), 64'(0));
        check("s4_short_pins", 64'(pins), 64'(9'h101));
        shift_frame(FRAME_B, FRAME_LEN);
        commit();
        left_in  = 20'h80000;
        right_in = 20'h80000;
        #1;
        check("s4_err",  64'(u_cfg.cfg_err), 64'(0));
        check("s4_pins", 64'(pins), 64'(9'h006));

        // 5: shift+commit together, tail latency, over-shift
        exp_q.delete();
        tail_chk = 1'b1;
        shift_frame(FRAME_C, FRAME_LEN);
        shift_bit(1'b1, 1'b1);
        check("s5_cnt1",  64'(dbg_cnt), 64'(1));
        check("s5_err",   64'(u_cfg.cfg_err), 64'(0));
        left_in  = 20'h00001;
        right_in = 20'h00001;
        #1;
        check("s5_pins",  64'(pins), 64'(9'h018));
        for (int i = 0; i < 60; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
        check("s5_cnt_sat", 64'(dbg_cnt), 64'(55));
        shift_frame(FRAME_A, FRAME_LEN);
        check("s5_cnt_sat2", 64'(dbg_cnt), 64'(55));
        commit();
        left_in  = 20'h00004;
        right_in = 20'h00010;
        #1;
        check("s5_over_err",  64'(u_cfg.cfg_err), 64'(0));
        check("s5_over_pins", 64'(pins), 64'(9'h101));
        tail_chk = 1'b0;

        // 6: reset mid-shift after a valid commit, then out-of-range select
        shift_frame(FRAME_A, 20);
        commit();
        check("s6_pre_err", 64'(u_cfg.cfg_err), 64'(1));
        shift_frame(FRAME_B, 10);
        left_in           = '1;
        right_in          = '1;
        pReset            = 1'b1;
        u_cfg.ccff_head   = 1'b1;
        u_cfg.ccff_en     = 1'b1;
        u_cfg.ccff_commit = 1'b1;
        tick();
        pReset            = 1'b0;
        u_cfg.ccff_en     = 1'b0;
        u_cfg.ccff_commit = 1'b0;
        #1;
        check("s6_rst_cnt",   64'(dbg_cnt), 64'(0));
        check("s6_rst_valid", 64'(u_cfg.cfg_valid), 64'(0));
        check("s6_rst_err",   64'(u_cfg.cfg_err), 64'(0));
        check("s6_rst_tail",  64'(u_cfg.ccff_tail), 64'(0));
        check("s6_rst_pins",  64'(pins), 64'(9'h000));
        shift_frame(FRAME_D, FRAME_LEN);
        commit();
        check("s6_d_valid", 64'(u_cfg.cfg_valid), 64'(1));
        check("s6_d_err",   64'(u_cfg.cfg_err), 64'(0));
        check("s6_d_pins",  64'(pins), 64'(9'h002));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
